// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a small input FIFO, runtime baud divisor, optional parity
// and 1/2 stop bits. Divisor and framing options are frozen per frame at pop time.
module uart_tx_fifo_cfg #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter int DEF_DIV    = 217
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic                            cfg_div_load,
    input  logic                            cfg_par_en,
    input  logic                            cfg_par_odd,
    input  logic                            cfg_two_stop,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            frame_done
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = AW + 1;
    localparam int BITN_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [LVL_W-1:0]  r_wptr;
    logic [LVL_W-1:0]  r_rptr;

    state_t            r_state;
    logic              r_tx;
    logic              r_done;
    logic [DIV_W-1:0]  r_div_cfg;
    logic [DIV_W-1:0]  r_div;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_two_stop;
    logic [DATA_W-1:0] r_shift;
    logic [BITN_W-1:0] r_bitn;
    logic [DIV_W:0]    r_cnt;

    logic [LVL_W-1:0]  w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rdata;
    logic [DIV_W-1:0]  w_div_sat;
    logic [DIV_W:0]    w_stop_len;
    logic              w_bit_end;
    logic              w_stop_end;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_level   = r_wptr - r_rptr;
    assign w_full    = (w_level == LVL_W'(FIFO_DEPTH));
    assign w_empty   = (w_level == '0);
    assign s_ready   = !reset && !w_full;
    assign w_push    = s_valid && s_ready;
    assign w_rdata   = r_mem[r_rptr[AW-1:0]];

    assign w_div_sat  = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign w_stop_len = r_two_stop ? {r_div, 1'b0} : {1'b0, r_div};
    assign w_bit_end  = (r_cnt == ({1'b0, r_div} - (DIV_W+1)'(1)));
    assign w_stop_end = (r_cnt == (w_stop_len - (DIV_W+1)'(1)));

    // A new frame starts from IDLE, or straight out of the last stop cycle.
    assign w_pop = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + LVL_W'(1);
            if (w_pop)  r_rptr <= r_rptr + LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_div_cfg  <= DIV_W'(DEF_DIV);
            r_div      <= DIV_W'(DEF_DIV);
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_shift    <= '0;
            r_bitn     <= '0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            if (cfg_div_load) r_div_cfg <= w_div_sat;

            // The line follows the state one cycle later, so each bit keeps its full width.
            case (r_state)
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= r_shift[0];
                S_PARITY: r_tx <= r_par_bit;
                default:  r_tx <= 1'b1;
            endcase

            case (r_state)
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + (DIV_W+1)'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bitn == BITN_W'(DATA_W - 1)) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bitn <= r_bitn + BITN_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + (DIV_W+1)'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + (DIV_W+1)'(1);
                    end
                end
                S_STOP: begin
                    if (w_stop_end) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + (DIV_W+1)'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase

            if (w_pop) begin
                r_state    <= S_START;
                r_cnt      <= '0;
                r_bitn     <= '0;
                r_shift    <= w_rdata;
                r_div      <= r_div_cfg;
                r_par_en   <= cfg_par_en;
                r_par_bit  <= (^w_rdata) ^ cfg_par_odd;
                r_two_stop <= cfg_two_stop;
            end
        end
    end

    assign tx         = r_tx;
    assign frame_done = r_done;
    assign fifo_level = w_level;
    assign busy       = (r_state != S_IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Drives uart_tx_fifo_cfg with directed and random traffic and compares every cycle
// against a waveform-level model built from queued bytes and frame rules.
module tb_uart_tx_fifo_cfg;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 16;
    localparam int DEF_DIV    = 217;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_div_load = 1'b0;
    logic              cfg_par_en = 1'b0;
    logic              cfg_par_odd = 1'b0;
    logic              cfg_two_stop = 1'b0;
    logic              tx;
    logic              busy;
    logic [LVL_W-1:0]  fifo_level;
    logic              frame_done;

    uart_tx_fifo_cfg #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cfg_div(cfg_div), .cfg_div_load(cfg_div_load), .cfg_par_en(cfg_par_en),
        .cfg_par_odd(cfg_par_odd), .cfg_two_stop(cfg_two_stop), .tx(tx), .busy(busy),
        .fifo_level(fifo_level), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic done;
    } smp_t;

    // Model: bytes waiting in the FIFO, and the exact future line samples of frames already started.
    logic [DATA_W-1:0] mq[$];
    smp_t              wave[$];
    int                d_cfg = DEF_DIV;
    logic              exp_tx = 1'b1;
    logic              exp_done = 1'b0;
    int                total = 0;
    int                bad = 0;
    int                done_seen = 0;
    bit                last_accept = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_frame(input logic [DATA_W-1:0] d, input int div, input bit pe, input bit po, input bit ts);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ po);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < div; k++) begin
                wave.push_back('{tx: bits[b], done: (b == bits.size() - 1) && (k == div - 1)});
            end
        end
    endtask

    // One clock: advance the model over the coming edge, then compare after it.
    task automatic tick();
        bit          do_pop;
        bit          do_push;
        logic [DATA_W-1:0] pdata;
        smp_t        e;
        pdata = '0;
        if (reset) begin
            mq.delete();
            wave.delete();
            d_cfg    = DEF_DIV;
            exp_tx   = 1'b1;
            exp_done = 1'b0;
            do_push  = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && (wave.size() <= 1);
            do_push = s_valid && (mq.size() < FIFO_DEPTH);
            if (do_pop) pdata = mq.pop_front();
            if (wave.size() != 0) begin
                e = wave.pop_front();
                exp_tx   = e.tx;
                exp_done = e.done;
            end else begin
                exp_tx   = 1'b1;
                exp_done = 1'b0;
            end
            if (do_pop) add_frame(pdata, d_cfg, cfg_par_en, cfg_par_odd, cfg_two_stop);
            if (do_push) mq.push_back(s_data);
            if (cfg_div_load) d_cfg = (cfg_div < 2) ? 2 : int'(cfg_div);
        end
        last_accept = do_push;
        if (do_push) $display("push data=%02h level=%0d", s_data, mq.size());
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) done_seen++;
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("busy", 32'(busy), 32'((wave.size() != 0) || (mq.size() != 0)));
        chk("s_ready", 32'(s_ready), 32'(!reset && (mq.size() < FIFO_DEPTH)));
    endtask

    task automatic push(input logic [DATA_W-1:0] b);
        int n;
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 5000);
        if (!last_accept) chk("push_timeout", 32'(n), 32'(0));
        s_valid = 1'b0;
    endtask

    task automatic load_div(input int v);
        cfg_div      = DIV_W'(v);
        cfg_div_load = 1'b1;
        tick();
        cfg_div_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wave.size() != 0 || mq.size() != 0) && n < 20000) begin
            tick();
            n++;
        end
        tick();
        tick();
    endtask

    initial begin
        int d0;
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 8N1 at D=4, 0x55
        load_div(4);
        push(8'h55);
        drain();

        // Even then odd parity, two stop bits, 0xA5
        cfg_par_en = 1'b1; cfg_two_stop = 1'b1; cfg_par_odd = 1'b0;
        push(8'hA5);
        drain();
        cfg_par_odd = 1'b1;
        push(8'hA5);
        drain();
        cfg_par_en = 1'b0; cfg_two_stop = 1'b0; cfg_par_odd = 1'b0;

        // Six bytes back-to-back into a 4-deep FIFO
        d0 = done_seen;
        for (int i = 0; i < 6; i++) push(DATA_W'($urandom));
        drain();
        chk("burst_frames", 32'(done_seen - d0), 32'd6);

        // Reset mid-DATA with bytes queued; line must stay idle afterwards
        for (int i = 0; i < 3; i++) push(DATA_W'($urandom));
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d0 = done_seen;
        repeat (40) tick();
        chk("post_reset_frames", 32'(done_seen - d0), 32'd0);
        load_div(4);

        // Divisor and parity change in the middle of a frame
        push(8'h3C);
        push(8'hC3);
        repeat (10) tick();
        cfg_par_en = 1'b1;
        load_div(8);
        drain();
        cfg_par_en = 1'b0;

        // Divisors below 2 clamp to 2
        load_div(0);
        push(8'h96);
        drain();
        load_div(1);
        cfg_two_stop = 1'b1;
        push(8'h69);
        drain();
        cfg_two_stop = 1'b0;

        // Random traffic and configuration
        load_div(3);
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) == 0);
            s_data  = DATA_W'($urandom);
            if ($urandom_range(0, 60) == 0) cfg_par_en   = 1'($urandom);
            if ($urandom_range(0, 60) == 0) cfg_par_odd  = 1'($urandom);
            if ($urandom_range(0, 60) == 0) cfg_two_stop = 1'($urandom);
            cfg_div      = DIV_W'($urandom_range(0, 5));
            cfg_div_load = ($urandom_range(0, 150) == 0);
            reset        = (c == 1500);
            if (c == 1501) begin
                cfg_div      = DIV_W'(3);
                cfg_div_load = 1'b1;
            end
            tick();
        end
        s_valid = 1'b0;
        cfg_div_load = 1'b0;
        reset = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
